// File: rtl/activation_cache_if.sv
// Handshake and tap-bus bundle between an activation producer, the
// activation_cache history buffer and the downstream four-tap conv1d stage.
// Packed vectors carry D signed lanes of W bits each, lane 0 in the MSBs.
interface activation_cache_if #(
  parameter int W = 16,
  parameter int D = 8
);
  logic           in_v;       // producer has a vector on packed_in
  logic           in_ready;   // cache can accept a vector this cycle
  logic [D*W-1:0] packed_in;  // newest activation vector
  logic [D*W-1:0] packed_a0;  // x[t-3*DILATION], oldest tap
  logic [D*W-1:0] packed_a1;  // x[t-2*DILATION]
  logic [D*W-1:0] packed_a2;  // x[t-DILATION]
  logic [D*W-1:0] packed_a3;  // x[t], newest tap
  logic           out_v;      // tap buses hold a complete tap set
  logic           out_ack;    // consumer has taken the tap set

  // Producer/consumer side of the cache.
  modport master (
    output in_v, packed_in, out_ack,
    input  in_ready, packed_a0, packed_a1, packed_a2, packed_a3, out_v
  );

  // The cache itself.
  modport slave (
    input  in_v, packed_in, out_ack,
    output in_ready, packed_a0, packed_a1, packed_a2, packed_a3, out_v
  );
endinterface

// File: rtl/activation_cache.sv
// Dilated causal history buffer for a four-tap conv1d stage.
// Each accepted vector is written into a circular buffer of DEPTH entries;
// the four taps (current vector and three older ones, DILATION steps apart)
// are then read out one per cycle into the tap registers and held until the
// consumer acknowledges. Taps reaching back before the first stored vector
// read as zero (causal padding). Data passes through bit-exact.
module activation_cache #(
  parameter int W        = 16,
  parameter int D        = 8,
  parameter int DILATION = 1
) (
  input  logic              clk,
  input  logic              rst,
  activation_cache_if.slave bus
);

  localparam int DEPTH = 3 * DILATION + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int VW    = D * W;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  localparam logic [AW-1:0] OFF1     = AW'(DILATION);
  localparam logic [AW-1:0] OFF2     = AW'(2 * DILATION);
  localparam logic [AW-1:0] OFF3     = AW'(3 * DILATION);

  typedef enum logic [2:0] {
    IDLE,
    READ0,
    READ1,
    READ2,
    READ3,
    VALID
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] newest_q, newest_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [VW-1:0] tap_q [4];
  logic [VW-1:0] tap_d [4];
  logic [VW-1:0] mem_q [DEPTH];

  logic          in_ready;
  logic          accept;
  logic          rd_en;
  logic [1:0]    rd_k;
  logic [AW-1:0] rd_off;
  logic [AW-1:0] rd_addr;
  logic [VW-1:0] rd_data;

  // The cache only listens in IDLE, and never while reset is held.
  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = bus.in_v && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_v     = (state_q == VALID);
  assign bus.packed_a0 = tap_q[0];
  assign bus.packed_a1 = tap_q[1];
  assign bus.packed_a2 = tap_q[2];
  assign bus.packed_a3 = tap_q[3];

  // Tap read: READk fetches tap j = 3-k from (newest - j*DILATION) mod DEPTH.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rd_en  = 1'b1;
    rd_k   = 2'd0;
    rd_off = OFF3;
    unique case (state_q)
      READ0:   begin rd_k = 2'd0; rd_off = OFF3; end
      READ1:   begin rd_k = 2'd1; rd_off = OFF2; end
      READ2:   begin rd_k = 2'd2; rd_off = OFF1; end
      READ3:   begin rd_k = 2'd3; rd_off = '0;   end
      default: rd_en = 1'b0;
    endcase
    // Wrap by conditional add of DEPTH; the true result lies in [0, DEPTH),
    // so AW-bit modular arithmetic gives it exactly.
    if (newest_q >= rd_off) begin
      rd_addr = newest_q - rd_off;
    end else begin
      rd_addr = newest_q + (DEPTH_A - rd_off);
    end
    // Entries not yet written since reset are masked to zero.
    rd_data = (fill_q > FW'(rd_off)) ? mem_q[rd_addr] : '0;
  end

  // Next-state and datapath update for the accept / read-out / ack sequence.
  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    newest_d = newest_q;
    fill_d   = fill_q;
    tap_d    = tap_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          newest_d = wp_q;
          fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
          state_d  = READ0;
        end
      end
      READ0: state_d = READ1;
      READ1: state_d = READ2;
      READ2: state_d = READ3;
      READ3: state_d = VALID;
      VALID: begin
        if (bus.out_ack) begin
          wp_d    = (wp_q == LAST_PTR) ? '0 : wp_q + AW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd_en) begin
      tap_d[rd_k] = rd_data;
    end
  end

  // Control and tap registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values together.
    if (rst) begin
      state_q  <= IDLE;
      wp_q     <= '0;
      newest_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        tap_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      newest_q <= newest_d;
      fill_q   <= fill_d;
      tap_q    <= tap_d;
    end
  end

  // History storage, written only on an accepted handshake.
  always_ff @(posedge clk) begin
    // NOTE: the history array has no reset; fill masks stale entries, keeping it plain storage.
    if (accept) begin
      mem_q[wp_q] <= bus.packed_in;
    end
  end

endmodule
